// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_pkg
// Description : Shared encodings for the multi-channel PWM generator.
//               - register-write target select
//               - control-word bit positions
//               - counting mode and direction
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    // Register-write target selected by the 2-bit sel input
    typedef enum logic [1:0] {
        SEL_CTRL = 2'b00,
        SEL_CMP  = 2'b01,
        SEL_TOP  = 2'b10,
        SEL_CNT  = 2'b11
    } sel_e;

    typedef enum logic {
        MODE_EDGE   = 1'b0,
        MODE_CENTER = 1'b1
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Bit positions inside a ctrl write word
    localparam int CTRL_EN     = 0;
    localparam int CTRL_MODE   = 1;
    localparam int CTRL_FORCE  = 2;
    localparam int CTRL_POLWR  = 3;
    localparam int CTRL_POLVAL = 4;

endpackage
`default_nettype wire

// File: rtl/pwm_channel.sv
`default_nettype none
// ============================================================================
// Module      : pwm_channel
// Description : One PWM compare channel. Holds a double-buffered compare
//               value (shadow written by the bus, active loaded on transfer)
//               and drives out = enable & (cnt < cmp_act).
//               Optional macro PWM_POLARITY_EN adds a per-channel polarity bit
//               that inverts the output and sets the idle level.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               cmp_we        - write d into the compare shadow
//               transfer      - copy shadow to active (period boundary)
//               d             - write data
//               cnt           - shared period counter
//               en            - global enable
//               pol_we/pol_val- polarity write (PWM_POLARITY_EN only)
//               out           - PWM output
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmp_we,
    input  logic         transfer,
    input  logic [W-1:0] d,
    input  logic [W-1:0] cnt,
    input  logic         en,
`ifdef PWM_POLARITY_EN
    input  logic         pol_we,
    input  logic         pol_val,
`endif
    output logic         out
);

    logic [W-1:0] r_cmp_sh;
    logic [W-1:0] r_cmp_act;
    logic         w_match;

    // Transfer reads the shadow before a same-edge write replaces it, so a
    // write in the boundary cycle only takes effect one period later.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmp_sh  <= '0;
            r_cmp_act <= '0;
        end else begin
            if (transfer) begin
                r_cmp_act <= r_cmp_sh;
            end
            if (cmp_we) begin
                r_cmp_sh <= d;
            end
        end
    end

    assign w_match = (cnt < r_cmp_act);

`ifdef PWM_POLARITY_EN
    logic r_pol;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pol <= 1'b0;
        end else if (pol_we) begin
            r_pol <= pol_val;
        end
    end

    assign out = en ? (w_match ^ r_pol) : r_pol;
`else
    assign out = en & w_match;
`endif

endmodule
`default_nettype wire

// File: rtl/pwm_multi.sv
`default_nettype none
// ============================================================================
// Module      : pwm_multi
// Description : Multi-channel PWM generator. One shared period counter
//               (edge- or center-aligned) feeds CH compare channels. Top and
//               compare values are double-buffered and move to the active
//               registers only at a period boundary.
//               Optional macro PWM_POLARITY_EN: per-channel output polarity,
//               written via ctrl word bits 3 (write) and 4 (value).
// Ports       : clk, rst   - clock, synchronous active-high reset
//               we         - write strobe for d/sel/ch
//               sel        - 00 ctrl, 01 cmp[ch], 10 top, 11 direct cnt load
//               ch         - channel index for cmp/polarity writes
//               d          - write data
//               out        - PWM outputs, one per channel
//               cnt        - current counter value
//               top        - active top value
//               period_end - one-cycle period boundary pulse
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_multi
    import pwm_pkg::*;
#(
    parameter  int W   = 16,
    parameter  int CH  = 4,
    localparam int CHW = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           we,
    input  logic [1:0]     sel,
    input  logic [CHW-1:0] ch,
    input  logic [W-1:0]   d,
    output logic [CH-1:0]  out,
    output logic [W-1:0]   cnt,
    output logic [W-1:0]   top,
    output logic           period_end
);

    logic [W-1:0] r_cnt;
    dir_e         r_dir;
    logic         r_en;
    mode_e        r_mode;
    logic [W-1:0] r_top_act;
    logic [W-1:0] r_top_sh;

    sel_e         w_sel;
    logic         w_ctrl_wr;
    logic         w_force;
    logic         w_load;
    logic         w_pe;
    logic         w_transfer;
    logic [W-1:0] w_cnt_nxt;
    dir_e         w_dir_nxt;

    assign w_sel     = sel_e'(sel);
    assign w_ctrl_wr = we && (w_sel == SEL_CTRL);
    assign w_force   = w_ctrl_wr && d[CTRL_FORCE];
    assign w_load    = we && (w_sel == SEL_CNT);

    // Boundary: wrap point in edge mode, valley in center mode. A zero top
    // pins the counter at 0, so every enabled cycle is a boundary.
    always_comb begin
        w_pe = 1'b0;
        if (r_en) begin
            if (r_mode == MODE_EDGE) begin
                w_pe = (r_cnt >= r_top_act);
            end else begin
                w_pe = (r_top_act == '0) || ((r_dir == DIR_DOWN) && (r_cnt == '0));
            end
        end
    end

    // A direct counter load owns the edge, so it also blocks the transfer.
    assign w_transfer = w_force || (w_pe && !w_load);

    always_comb begin
        w_cnt_nxt = r_cnt;
        w_dir_nxt = r_dir;
        if (w_force) begin
            w_cnt_nxt = '0;
            w_dir_nxt = DIR_UP;
        end else if (w_load) begin
            w_cnt_nxt = d;
            if ((r_mode == MODE_CENTER) && (d >= r_top_act)) begin
                w_dir_nxt = DIR_DOWN;
            end
        end else if (r_en) begin
            if (r_mode == MODE_EDGE) begin
                w_cnt_nxt = (r_cnt >= r_top_act) ? '0 : r_cnt + W'(1);
            end else if (r_top_act == '0) begin
                w_cnt_nxt = '0;
                w_dir_nxt = DIR_UP;
            end else if (r_dir == DIR_UP) begin
                if (r_cnt >= r_top_act) begin
                    w_cnt_nxt = r_cnt - W'(1);
                    w_dir_nxt = DIR_DOWN;
                end else begin
                    w_cnt_nxt = r_cnt + W'(1);
                end
            end else if (r_cnt == '0) begin
                w_cnt_nxt = W'(1);
                w_dir_nxt = DIR_UP;
            end else begin
                w_cnt_nxt = r_cnt - W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_dir     <= DIR_UP;
            r_en      <= 1'b0;
            r_mode    <= MODE_EDGE;
            r_top_act <= '1;
            r_top_sh  <= '1;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_dir <= w_dir_nxt;
            if (w_transfer) begin
                r_top_act <= r_top_sh;
            end
            if (w_ctrl_wr) begin
                r_en   <= d[CTRL_EN];
                r_mode <= mode_e'(d[CTRL_MODE]);
            end
            if (we && (w_sel == SEL_TOP)) begin
                r_top_sh <= d;
            end
        end
    end

    // Out-of-range ch never matches any index, so such writes are dropped.
    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic w_cmp_we;
        assign w_cmp_we = we && (w_sel == SEL_CMP) && (ch == CHW'(i));
`ifdef PWM_POLARITY_EN
        logic w_pol_we;
        assign w_pol_we = w_ctrl_wr && d[CTRL_POLWR] && (ch == CHW'(i));
`endif
        pwm_channel #(
            .W (W)
        ) u_channel (
            .clk      (clk),
            .rst      (rst),
            .cmp_we   (w_cmp_we),
            .transfer (w_transfer),
            .d        (d),
            .cnt      (r_cnt),
            .en       (r_en),
`ifdef PWM_POLARITY_EN
            .pol_we   (w_pol_we),
            .pol_val  (d[CTRL_POLVAL]),
`endif
            .out      (out[i])
        );
    end

    assign cnt        = r_cnt;
    assign top        = r_top_act;
    assign period_end = w_pe;

endmodule
`default_nettype wire
